// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: three-entry switch combination lock with a timed unlock window and a timed lockout.
// Optional macro COMBO_LOCK_ENTRY_TIMEOUT_EN aborts a partial sequence after ENTRY_TIMEOUT idle cycles.
module combo_lock_ctrl #(
  parameter logic [7:0]  CODE0          = 8'h28,
  parameter logic [7:0]  CODE1          = 8'h19,
  parameter logic [7:0]  CODE2          = 8'h96,
  parameter int unsigned MAX_TRIES      = 3,
  parameter logic [31:0] UNLOCK_CYCLES  = 32'd250_000_000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd500_000_000,
  parameter logic [31:0] ENTRY_TIMEOUT  = 32'd250_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       enter,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] step,
  output logic [1:0] fail_count,
  output logic       bad_code
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_E1      = 3'd1,
    S_E2      = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam logic [1:0] MAX_C = 2'(MAX_TRIES);

  state_t      state_q, state_d;
  logic        enter_d_q;
  logic        mismatch_q, mismatch_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  fail_count_q, fail_count_d;
  logic [1:0]  step_q, step_d;
  logic        unlocked_q, locked_out_q, bad_code_q, bad_code_d;
  logic        press_s, timeout_s, fail_seq_s;
  logic [1:0]  fail_inc_s;
  logic [7:0]  entry_s;

  assign press_s    = enter & ~enter_d_q;
  assign entry_s    = {A, B};
  assign fail_inc_s = (fail_count_q >= MAX_C) ? fail_count_q : (fail_count_q + 2'd1);

`ifdef COMBO_LOCK_ENTRY_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        in_seq_s;

  assign in_seq_s  = (state_q == S_E1) || (state_q == S_E2);
  // A press in the expiry cycle wins, so expiry requires no press.
  assign timeout_s = in_seq_s && !press_s && (idle_q == (ENTRY_TIMEOUT - 32'd1));

  // Idle counter next value: counts only while waiting for the next entry.
  always_comb begin
    idle_d = 32'd0;
    if (in_seq_s && !press_s && !timeout_s) begin
      idle_d = idle_q + 32'd1;
    end else begin
      idle_d = 32'd0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^ENTRY_TIMEOUT;
  assign timeout_s        = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    mismatch_d   = mismatch_q;
    timer_d      = timer_q;
    fail_count_d = fail_count_q;
    step_d       = step_q;
    bad_code_d   = 1'b0;
    fail_seq_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press_s) begin
          state_d    = S_E1;
          step_d     = 2'd1;
          mismatch_d = (entry_s != CODE0);
        end else begin
          step_d = 2'd0;
        end
      end
      S_E1: begin
        if (press_s) begin
          state_d    = S_E2;
          step_d     = 2'd2;
          mismatch_d = mismatch_q | (entry_s != CODE1);
        end else if (timeout_s) begin
          fail_seq_s = 1'b1;
        end else begin
          state_d = S_E1;
        end
      end
      S_E2: begin
        if (press_s) begin
          step_d = 2'd0;
          if (!mismatch_q && (entry_s == CODE2)) begin
            state_d      = S_OPEN;
            fail_count_d = 2'd0;
            timer_d      = UNLOCK_CYCLES - 32'd1;
          end else begin
            fail_seq_s = 1'b1;
          end
        end else if (timeout_s) begin
          fail_seq_s = 1'b1;
        end else begin
          state_d = S_E2;
        end
      end
      S_OPEN: begin
        // Expiry and a relocking press collapse into one return to IDLE.
        if ((timer_q == 32'd0) || press_s) begin
          state_d = S_IDLE;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == 32'd0) begin
          state_d      = S_IDLE;
          fail_count_d = 2'd0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 2'd0;
        timer_d = 32'd0;
      end
    endcase

    if (fail_seq_s) begin
      bad_code_d   = 1'b1;
      step_d       = 2'd0;
      fail_count_d = fail_inc_s;
      if (fail_inc_s == MAX_C) begin
        state_d = S_LOCKOUT;
        timer_d = LOCKOUT_CYCLES - 32'd1;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      bad_code_d = 1'b0;
    end
  end

  // State, datapath and registered outputs; enter_d resets high to mask a held strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      enter_d_q    <= 1'b1;
      mismatch_q   <= 1'b0;
      timer_q      <= 32'd0;
      fail_count_q <= 2'd0;
      step_q       <= 2'd0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      bad_code_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enter_d_q    <= enter;
      mismatch_q   <= mismatch_d;
      timer_q      <= timer_d;
      fail_count_q <= fail_count_d;
      step_q       <= step_d;
      unlocked_q   <= (state_d == S_OPEN);
      locked_out_q <= (state_d == S_LOCKOUT);
      bad_code_q   <= bad_code_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign step       = step_q;
  assign fail_count = fail_count_q;
  assign bad_code   = bad_code_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with short timers (unlock 8, lockout 16, entry timeout 10).
module tb_combo_lock_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] A;
  logic [3:0] B;
  logic       enter;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] step;
  logic [1:0] fail_count;
  logic       bad_code;

  int vectors;
  int miscompares;

  combo_lock_ctrl #(
    .CODE0          (8'h28),
    .CODE1          (8'h19),
    .CODE2          (8'h96),
    .MAX_TRIES      (3),
    .UNLOCK_CYCLES  (32'd8),
    .LOCKOUT_CYCLES (32'd16),
    .ENTRY_TIMEOUT  (32'd10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .enter      (enter),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .step       (step),
    .fail_count (fail_count),
    .bad_code   (bad_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are read there too.
  task automatic press_hold(input logic [7:0] code);
    {A, B} = code;
    enter  = 1'b1;
    @(negedge clock);
  endtask

  task automatic release_enter();
    enter = 1'b0;
    @(negedge clock);
  endtask

  task automatic entry(input logic [7:0] code);
    press_hold(code);
    release_enter();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enter = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enter = 1'b0;
    {A, B} = 8'h00;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if ({unlocked, locked_out, step, fail_count, bad_code} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_values: got %b expected 0000000", {unlocked, locked_out, step, fail_count, bad_code});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_unlock();
    do_reset();
    entry(8'h28);
    vectors++;
    if (step !== 2'd1) begin miscompares++; $display("FAIL step_after_1: got %0d expected 1", step); end
    entry(8'h19);
    vectors++;
    if (step !== 2'd2) begin miscompares++; $display("FAIL step_after_2: got %0d expected 2", step); end
    press_hold(8'h96);
    vectors++;
    if (unlocked !== 1'b1 || step !== 2'd0 || fail_count !== 2'd0) begin
      miscompares++;
      $display("FAIL unlock_edge: got u=%b step=%0d fc=%0d expected u=1 step=0 fc=0", unlocked, step, fail_count);
    end
    enter = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      vectors++;
      if (unlocked !== (c < 8)) begin
        miscompares++;
        $display("FAIL unlock_window c=%0d: got %b expected %b", c, unlocked, (c < 8));
      end
    end
  endtask

  task automatic test_bad_code();
    do_reset();
    entry(8'h28);
    entry(8'h19);
    press_hold(8'h97);
    vectors++;
    if (bad_code !== 1'b1 || fail_count !== 2'd1 || unlocked !== 1'b0 || step !== 2'd0) begin
      miscompares++;
      $display("FAIL bad_seq_edge: got bc=%b fc=%0d u=%b step=%0d expected bc=1 fc=1 u=0 step=0",
               bad_code, fail_count, unlocked, step);
    end
    release_enter();
    vectors++;
    if (bad_code !== 1'b0 || fail_count !== 2'd1 || unlocked !== 1'b0 || locked_out !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_seq_after: got bc=%b fc=%0d u=%b lo=%b expected bc=0 fc=1 u=0 lo=0",
               bad_code, fail_count, unlocked, locked_out);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      entry(8'h00); entry(8'h00); entry(8'h00);
    end
    vectors++;
    if (fail_count !== 2'd2 || locked_out !== 1'b0) begin
      miscompares++;
      $display("FAIL two_fails: got fc=%0d lo=%b expected fc=2 lo=0", fail_count, locked_out);
    end
    entry(8'h00); entry(8'h00);
    press_hold(8'h00);
    vectors++;
    if (locked_out !== 1'b1 || bad_code !== 1'b1 || fail_count !== 2'd3) begin
      miscompares++;
      $display("FAIL lockout_edge: got lo=%b bc=%b fc=%0d expected lo=1 bc=1 fc=3", locked_out, bad_code, fail_count);
    end
    {A, B} = 8'h28;
    // Presses at c=2,4,6 are ignored; the one landing on expiry (c=16) is discarded.
    for (int c = 1; c <= 16; c++) begin
      enter = (c == 2) || (c == 4) || (c == 6) || (c == 16);
      @(negedge clock);
      vectors++;
      if (c < 16) begin
        if (locked_out !== 1'b1 || step !== 2'd0 || unlocked !== 1'b0) begin
          miscompares++;
          $display("FAIL lockout_hold c=%0d: got lo=%b step=%0d u=%b expected lo=1 step=0 u=0", c, locked_out, step, unlocked);
        end
      end else begin
        if (locked_out !== 1'b0 || fail_count !== 2'd0 || step !== 2'd0) begin
          miscompares++;
          $display("FAIL lockout_end: got lo=%b fc=%0d step=%0d expected lo=0 fc=0 step=0", locked_out, fail_count, step);
        end
      end
    end
    release_enter();
    entry(8'h28);
    entry(8'h19);
    press_hold(8'h96);
    vectors++;
    if (unlocked !== 1'b1) begin miscompares++; $display("FAIL unlock_after_lockout: got %b expected 1", unlocked); end
    release_enter();
  endtask

  task automatic test_held_enter_and_relock();
    reset = 1'b1;
    {A, B} = 8'h28;
    enter = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vectors++;
      if (step !== 2'd0) begin miscompares++; $display("FAIL held_enter c=%0d: got step=%0d expected 0", c, step); end
    end
    release_enter();
    entry(8'h28);
    entry(8'h19);
    press_hold(8'h96);
    vectors++;
    if (unlocked !== 1'b1) begin miscompares++; $display("FAIL held_then_unlock: got %b expected 1", unlocked); end
    release_enter();
    @(negedge clock);
    press_hold(8'h28);
    vectors++;
    if (unlocked !== 1'b0 || step !== 2'd0) begin
      miscompares++;
      $display("FAIL relock_press: got u=%b step=%0d expected u=0 step=0", unlocked, step);
    end
    release_enter();
    vectors++;
    if (step !== 2'd0 || unlocked !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_not_entry: got u=%b step=%0d expected u=0 step=0", unlocked, step);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    entry(8'h00);
    entry(8'h00);
    entry(8'h00);
    entry(8'h28);
    entry(8'h19);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({unlocked, locked_out, step, fail_count, bad_code} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid_seq: got %b expected 0000000", {unlocked, locked_out, step, fail_count, bad_code});
    end
    reset = 1'b0;
    @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      entry(8'h00); entry(8'h00); entry(8'h00);
    end
    vectors++;
    if (locked_out !== 1'b1) begin miscompares++; $display("FAIL pre_reset_lockout: got %b expected 1", locked_out); end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({unlocked, locked_out, step, fail_count, bad_code} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid_lockout: got %b expected 0000000", {unlocked, locked_out, step, fail_count, bad_code});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

`ifdef COMBO_LOCK_ENTRY_TIMEOUT_EN
  task automatic test_entry_timeout();
    do_reset();
    press_hold(8'h28);
    enter = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      vectors++;
      if (c < 10) begin
        if (bad_code !== 1'b0 || step !== 2'd1) begin
          miscompares++;
          $display("FAIL timeout_wait c=%0d: got bc=%b step=%0d expected bc=0 step=1", c, bad_code, step);
        end
      end else begin
        if (bad_code !== 1'b1 || fail_count !== 2'd1 || step !== 2'd0) begin
          miscompares++;
          $display("FAIL timeout_fire: got bc=%b fc=%0d step=%0d expected bc=1 fc=1 step=0", bad_code, fail_count, step);
        end
      end
    end
  endtask
`else
  task automatic test_entry_timeout();
    do_reset();
    entry(8'h28);
    for (int c = 0; c < 100; c++) @(negedge clock);
    vectors++;
    if (step !== 2'd1 || bad_code !== 1'b0) begin
      miscompares++;
      $display("FAIL no_timeout_wait: got step=%0d bc=%b expected step=1 bc=0", step, bad_code);
    end
    entry(8'h19);
    press_hold(8'h96);
    vectors++;
    if (unlocked !== 1'b1 || fail_count !== 2'd0) begin
      miscompares++;
      $display("FAIL no_timeout_unlock: got u=%b fc=%0d expected u=1 fc=0", unlocked, fail_count);
    end
    release_enter();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    enter       = 1'b0;
    A           = 4'd0;
    B           = 4'd0;
    test_reset();
    test_unlock();
    test_bad_code();
    test_lockout();
    test_held_enter_and_relock();
    test_reset_midway();
    test_entry_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
